// File: rtl/bp_me_fifo_credit_arbiter.sv
// bp_me_fifo_credit_arbiter: round-robin, credit-limited fwd arbiter with in-order rev steering.
// BP_ME_FIFO_ARB_RESP_CHECK_EN: accept and flag orphan responses instead of stalling them.
module bp_me_fifo_credit_arbiter #(
  parameter int num_req_p     = 2,
  parameter int num_credits_p = 8,
  parameter int fwd_width_p   = 168,
  parameter int rev_width_p   = 168
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p*fwd_width_p-1:0]   fwd_i,
  input  logic [num_req_p-1:0]               fwd_v_i,
  output logic [num_req_p-1:0]               fwd_ready_and_o,
  output logic [fwd_width_p-1:0]             fwd_o,
  output logic                               fwd_v_o,
  input  logic                               fwd_ready_and_i,
  input  logic [rev_width_p-1:0]             rev_i,
  input  logic                               rev_v_i,
  output logic                               rev_ready_and_o,
  output logic [rev_width_p-1:0]             rev_o,
  output logic [num_req_p-1:0]               rev_v_o,
  input  logic [num_req_p-1:0]               rev_ready_and_i,
  input  logic                               drain_i,
  output logic                               idle_o,
  output logic [$clog2(num_credits_p+1)-1:0] credits_used_o,
  output logic                               err_o
);
  localparam int idw = $clog2(num_req_p);
  localparam int pw  = num_credits_p > 1 ? $clog2(num_credits_p) : 1;
  localparam int cw  = $clog2(num_credits_p+1);
  logic [idw-1:0] last_r, lock_id_r, g, h;
  logic           locked_r;
  logic [idw-1:0] trk_r [num_credits_p];
  logic [pw-1:0]  wptr_r, rptr_r;
  logic           empty, full, issue_ok, fwd_hs, rev_hs;
  function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
    return p == pw'(num_credits_p-1) ? '0 : p + 1'b1;
  endfunction
  // Scan downward so the nearest valid requester after last_r wins.
  always_comb begin
    g = locked_r ? lock_id_r : idw'((int'(last_r) + 1) % num_req_p);
    if (!locked_r)
      for (int i = num_req_p; i >= 1; i--)
        if (fwd_v_i[idw'((int'(last_r) + i) % num_req_p)]) g = idw'((int'(last_r) + i) % num_req_p);
  end
  assign empty           = credits_used_o == '0;
  assign full            = credits_used_o == cw'(num_credits_p);
  assign issue_ok        = !full & (locked_r | !drain_i);
  assign fwd_v_o         = issue_ok & fwd_v_i[g];
  assign fwd_o           = fwd_i[g*fwd_width_p +: fwd_width_p];
  assign fwd_ready_and_o = num_req_p'(fwd_ready_and_i & issue_ok) << g;
  assign h               = trk_r[rptr_r];
  assign rev_o           = rev_i;
  assign rev_v_o         = num_req_p'(rev_v_i & !empty) << h;
`ifdef BP_ME_FIFO_ARB_RESP_CHECK_EN
  assign rev_ready_and_o = empty | rev_ready_and_i[h];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) err_o <= 1'b0;
    else if (rev_v_i & empty) err_o <= 1'b1;
`else
  assign rev_ready_and_o = !empty & rev_ready_and_i[h];
  assign err_o           = 1'b0;
`endif
  assign fwd_hs = fwd_v_o & fwd_ready_and_i;
  assign rev_hs = rev_v_i & rev_ready_and_o & !empty;
  assign idle_o = empty & !locked_r;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      last_r         <= idw'(num_req_p-1);
      locked_r       <= 1'b0;
      lock_id_r      <= '0;
      wptr_r         <= '0;
      rptr_r         <= '0;
      credits_used_o <= '0;
    end else begin
      if (fwd_v_o & !fwd_ready_and_i) begin
        locked_r  <= 1'b1;
        lock_id_r <= g;
      end
      if (fwd_hs) begin
        locked_r <= 1'b0;
        last_r   <= g;
        wptr_r   <= nxt(wptr_r);
      end
      if (rev_hs) rptr_r <= nxt(rptr_r);
      credits_used_o <= credits_used_o + cw'(fwd_hs) - cw'(rev_hs);
    end
  always_ff @(posedge clk_i)
    if (fwd_hs) trk_r[wptr_r] <= g;
endmodule

// File: tb/tb_bp_me_fifo_credit_arbiter.sv
// tb_bp_me_fifo_credit_arbiter: vector table plus directed credit, orphan and reset sequences.
module tb_bp_me_fifo_credit_arbiter;
`ifdef BP_ME_FIFO_ARB_RESP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         reset_i;
  logic [335:0] fwd_i;
  logic [1:0]   fwd_v_i, fwd_ready_and_o, rev_v_o, rev_ready_and_i;
  logic [167:0] fwd_o, rev_i, rev_o;
  logic         fwd_v_o, fwd_ready_and_i, rev_v_i, rev_ready_and_o, drain_i, idle_o, err_o;
  logic [3:0]   credits_used_o;
  int checks = 0, errors = 0, hs;
  always #5 clk = ~clk;
  bp_me_fifo_credit_arbiter #(.num_req_p(2), .num_credits_p(8), .fwd_width_p(168), .rev_width_p(168)) dut (
    .clk_i(clk), .reset_i(reset_i), .fwd_i(fwd_i), .fwd_v_i(fwd_v_i), .fwd_ready_and_o(fwd_ready_and_o),
    .fwd_o(fwd_o), .fwd_v_o(fwd_v_o), .fwd_ready_and_i(fwd_ready_and_i), .rev_i(rev_i), .rev_v_i(rev_v_i),
    .rev_ready_and_o(rev_ready_and_o), .rev_o(rev_o), .rev_v_o(rev_v_o), .rev_ready_and_i(rev_ready_and_i),
    .drain_i(drain_i), .idle_o(idle_o), .credits_used_o(credits_used_o), .err_o(err_o));
  function automatic logic [167:0] pat(input int k);
    return {21{8'h5a ^ 8'(k)}};
  endfunction
  task automatic chk(input string nm, input logic [167:0] a, input logic [167:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  typedef struct {
    logic [1:0] fv; logic fr; logic rv; logic [1:0] rr; logic dr;
    logic efv; logic [1:0] efr; int eg; logic [1:0] erv; logic err; int ecred; logic eidle;
  } vec_t;
  vec_t vt[19];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  initial begin
    // fv fr rv rr dr | efv efr eg erv rdy cred idle
    vt[0]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 0, 2'b00, 1'b0, 0, 1'b1};
    vt[1]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b01, 0, 2'b00, 1'b0, 0, 1'b1};
    vt[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b10, 1, 2'b01, 1'b1, 1, 1'b0};
    vt[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 0, 2'b10, 1'b1, 1, 1'b0};
    vt[4]  = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 0, 2'b01, 1'b1, 1, 1'b0};
    vt[5]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1, 2'b00, 1'b0, 0, 1'b1};
    vt[6]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1, 2'b00, 1'b0, 0, 1'b0};
    vt[7]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1, 2'b00, 1'b0, 0, 1'b0};
    vt[8]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1, 2'b00, 1'b0, 0, 1'b0};
    vt[9]  = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 0, 2'b00, 1'b0, 1, 1'b0};
    vt[10] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 0, 2'b00, 1'b0, 2, 1'b0};
    vt[11] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 0, 2'b10, 1'b1, 2, 1'b0};
    vt[12] = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 0, 2'b01, 1'b1, 1, 1'b0};
    vt[13] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 0, 2'b00, 1'b0, 0, 1'b1};
    vt[14] = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1, 2'b00, 1'b0, 0, 1'b1};
    vt[15] = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1, 2'b00, 1'b0, 0, 1'b0};
    vt[16] = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1, 2'b00, 1'b0, 0, 1'b0};
    vt[17] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 0, 2'b10, 1'b1, 1, 1'b0};
    vt[18] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0, 2'b00, 1'b0, 0, 1'b1};
    fwd_i = {pat(1), pat(0)};
    rev_i = {21{8'hc3}};
    reset_i = 1'b1; fwd_v_i = 2'b00; fwd_ready_and_i = 1'b1; rev_v_i = 1'b0; rev_ready_and_i = 2'b00; drain_i = 1'b0;
    #1;
    chk("reset_credits", credits_used_o, 0);
    chk("reset_idle", idle_o, 1);
    chk("reset_err", err_o, 0);
    chk("reset_fwd_v", fwd_v_o, 0);
    chk("reset_rev_v", rev_v_o, 0);
    @(posedge clk); #1 reset_i = 1'b0;
    for (int i = 0; i < 19; i++) begin
      fwd_v_i = vt[i].fv; fwd_ready_and_i = vt[i].fr; rev_v_i = vt[i].rv;
      rev_ready_and_i = vt[i].rr; drain_i = vt[i].dr;
      @(negedge clk);
      chk($sformatf("v%0d_fwd_v", i), fwd_v_o, vt[i].efv);
      chk($sformatf("v%0d_fwd_rdy", i), fwd_ready_and_o, vt[i].efr);
      if (vt[i].efv) chk($sformatf("v%0d_fwd_data", i), fwd_o, pat(vt[i].eg));
      chk($sformatf("v%0d_rev_v", i), rev_v_o, vt[i].erv);
      chk($sformatf("v%0d_rev_rdy", i), rev_ready_and_o, vt[i].ecred == 0 ? CHK : vt[i].err);
      chk($sformatf("v%0d_rev_data", i), rev_o, rev_i);
      chk($sformatf("v%0d_credits", i), credits_used_o, 168'(vt[i].ecred));
      chk($sformatf("v%0d_idle", i), idle_o, vt[i].eidle);
      @(posedge clk); #1;
    end
    fwd_v_i = 2'b01; fwd_ready_and_i = 1'b1; rev_v_i = 1'b0; rev_ready_and_i = 2'b01; drain_i = 1'b0;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fwd_v_o && fwd_ready_and_o[0]) hs++;
      @(posedge clk); #1;
    end
    chk("credit_limit_handshakes", 168'(hs), 8);
    @(negedge clk);
    chk("full_credits", credits_used_o, 8);
    chk("full_fwd_v", fwd_v_o, 0);
    chk("full_fwd_rdy", fwd_ready_and_o, 2'b00);
    rev_v_i = 1'b1;
    #1;
    chk("full_ret_no_issue", fwd_v_o, 0);
    chk("full_ret_rev_rdy", rev_ready_and_o, 1);
    @(posedge clk); #1 rev_v_i = 1'b0;
    chk("after_ret_credits", credits_used_o, 7);
    @(negedge clk);
    chk("reissue_fwd_v", fwd_v_o, 1);
    @(posedge clk); #1;
    chk("reissue_credits", credits_used_o, 8);
    fwd_v_i = 2'b00; rev_v_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain5_credits", credits_used_o, 3);
    fwd_v_i = 2'b01;
    @(negedge clk);
    chk("simul_fwd_v", fwd_v_o, 1);
    chk("simul_rev_rdy", rev_ready_and_o, 1);
    @(posedge clk); #1;
    chk("simul_credits", credits_used_o, 3);
    fwd_v_i = 2'b00;
    repeat (3) @(posedge clk);
    #1 rev_v_i = 1'b0;
    chk("empty_credits", credits_used_o, 0);
    chk("empty_idle", idle_o, 1);
    rev_v_i = 1'b1; rev_ready_and_i = 2'b11;
    #1;
    chk("orphan_rev_v", rev_v_o, 2'b00);
    chk("orphan_rev_rdy", rev_ready_and_o, CHK);
    @(posedge clk); #1 rev_v_i = 1'b0;
    chk("orphan_err", err_o, CHK);
    repeat (3) @(posedge clk);
    #1;
    chk("orphan_err_sticky", err_o, CHK);
    chk("orphan_credits", credits_used_o, 0);
    fwd_v_i = 2'b11;
    repeat (2) @(posedge clk);
    #1 fwd_v_i = 2'b00;
    chk("pre_reset_credits", credits_used_o, 2);
    #1 reset_i = 1'b1; rev_v_i = 1'b1;
    #1;
    chk("midreset_credits", credits_used_o, 0);
    chk("midreset_idle", idle_o, 1);
    chk("midreset_err", err_o, 0);
    chk("midreset_rev_v", rev_v_o, 2'b00);
    @(posedge clk); #1 reset_i = 1'b0; rev_v_i = 1'b0;
    fwd_v_i = 2'b11;
    @(negedge clk);
    chk("post_reset_grant", fwd_o, pat(0));
    chk("post_reset_rdy", fwd_ready_and_o, 2'b01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_me_fifo_credit_arbiter.md
# bp_me_fifo_credit_arbiter

Shares one BedRock memory endpoint between up to `num_req_p` requesters. Each requester presents packed mem_fwd messages (header plus data). The block round-robin arbitrates them onto a single credit-limited fwd channel. It records the winner's ID in an in-order tracker and steers each returning rev message back to the requester that issued the matching fwd. It sits upstream of the endpoint-to-FIFO bridge and keeps outstanding traffic within that bridge's credit budget.

## Interface
- `num_req_p`, 2: number of requesters, 2..8.
- `num_credits_p`, 8: maximum outstanding fwd messages, also the tracker depth.
- `fwd_width_p`, 168: packed fwd message width (header plus data).
- `rev_width_p`, 168: packed rev message width.
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `fwd_i` in `num_req_p*fwd_width_p`: requester messages; requester k occupies slice k.
- `fwd_v_i` in `num_req_p`: per-requester valid.
- `fwd_ready_and_o` out `num_req_p`: per-requester ready.
- `fwd_o` out `fwd_width_p`: granted message.
- `fwd_v_o` out 1: valid for `fwd_o`.
- `fwd_ready_and_i` in 1: downstream ready.
- `rev_i` in `rev_width_p`: returning message.
- `rev_v_i` in 1: valid for `rev_i`.
- `rev_ready_and_o` out 1: ready for `rev_i`.
- `rev_o` out `rev_width_p`: `rev_i` broadcast to all requesters.
- `rev_v_o` out `num_req_p`: one-hot valid to the owning requester.
- `rev_ready_and_i` in `num_req_p`: per-requester ready.
- `drain_i` in 1: blocks new grants.
- `idle_o` out 1: no outstanding messages and no lock held.
- `credits_used_o` out `BSG_WIDTH(num_credits_p)`: outstanding message count.
- `err_o` out 1: sticky protocol error flag.

## Operation
- State registers:
  - round-robin pointer `last_r`;
  - `locked_r` and `lock_id_r`;
  - credit counter `credits_used_o`;
  - tracker FIFO, `num_credits_p` x `clog2(num_req_p)`;
  - `err_o`.
- Grant selection:
  - When `locked_r` = 0, the grant goes to the first valid requester searching from `last_r`+1, with wrap-around.
  - When `locked_r` = 1, the grant is `lock_id_r` regardless of other valids.
- Issue enable: `issue_ok` = `credits_used_o` < `num_credits_p` AND tracker not full AND (`locked_r` OR !`drain_i`).
- `fwd_v_o` = `issue_ok` AND the granted requester's valid.
- `fwd_o` is the granted requester's slice. `fwd_ready_and_o`[g] = `fwd_ready_and_i` AND `issue_ok`; all other bits are 0.
- Lock: if `fwd_v_o` = 1 and `fwd_ready_and_i` = 0, set `locked_r` = 1 and `lock_id_r` = g. Requesters must hold valid and data stable until accepted.
- Fwd handshake (`fwd_v_o` AND `fwd_ready_and_i`):
  - clear `locked_r`;
  - set `last_r` = g;
  - enqueue g in the tracker;
  - increment `credits_used_o`.
- Rev path, with h = tracker head:
  - `rev_v_o`[h] = `rev_v_i` AND tracker non-empty; other bits are 0.
  - `rev_ready_and_o` = tracker non-empty AND `rev_ready_and_i`[h].
- Rev handshake: dequeue the tracker and decrement `credits_used_o`.
- Simultaneous fwd and rev handshakes in one cycle: the count is unchanged, and the tracker enqueues and dequeues together. This is legal even when the tracker is full, because the enqueue is blocked by `issue_ok` in that case.
- `idle_o` = (`credits_used_o` == 0) AND !`locked_r`.
- `drain_i` blocks only new grants. A locked transfer completes despite `drain_i`.

## Timing
- `fwd_i`→`fwd_o` and `rev_i`→`rev_o` are combinational: zero-cycle latency.
- Pointer, lock, tracker and count update on the rising `clk_i` edge after a handshake.
- A credit returned in cycle t allows an issue in cycle t+1. An issue and a return in the same cycle are both accepted.
- Values in reset (asynchronous): `last_r` = `num_req_p`-1, so requester 0 has first priority; `locked_r` = 0; tracker empty; `credits_used_o` = 0; `err_o` = 0; `idle_o` = 1; `fwd_v_o` = 0; `rev_v_o` = 0.
- Reset asserted mid-operation discards all outstanding tracking. Responses that arrive after reset are handled as in Configuration.

## Configuration
- `BP_ME_FIFO_ARB_RESP_CHECK_EN` defined:
  - A `rev_v_i` with the tracker empty is accepted: `rev_ready_and_o` = 1 and the message is dropped.
  - That event sets `err_o`, which holds until reset.
  - No requester sees `rev_v_o`.
- Undefined:
  - `err_o` is tied to 0.
  - `rev_ready_and_o` = 0 while the tracker is empty, so an orphan response stalls.

## Test plan
- **Fairness:** `num_req_p` = 2, both valid continuously, `fwd_ready_and_i` = 1, `rev_v_i` = 1 and `rev_ready_and_i` = 11 every cycle → grants alternate 0,1,0,1; responses route to requester 0, then 1, in issue order.
- **Lock:** requester 1 granted with `fwd_ready_and_i` = 0 for 3 cycles while requester 0 asserts valid → `fwd_o` stays requester 1 and is accepted on cycle 4; requester 0 is granted next.
- **Credit limit:** `num_credits_p` = 8, no responses → exactly 8 handshakes, `credits_used_o` = 8, `fwd_v_o` = 0. One response returns → one more issue on the next cycle.
- **Simultaneous events:** `credits_used_o` = 8, rev handshake and pending request in the same cycle → no issue that cycle; count 7 then 8. From count 3, issue and return together → count stays 3.
- **Drain and idle:** assert `drain_i` with 2 outstanding → no new grants; `idle_o` = 1 after the second rev handshake.
- **Orphan response:** `rev_v_i` = 1 with tracker empty → with the macro defined, `err_o` = 1 next cycle and stays set; without it, `rev_ready_and_o` stays 0.
